// File: rtl/i2c_slave.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave
// Purpose  : I2C target (responder) for 7-bit addressed, byte-oriented
//            transfers. SCL/SDA are oversampled on clk. The block detects
//            START, repeated START and STOP, and matches DEV_ADDR. Write
//            bytes go to user logic with a one-cycle rx_valid pulse. Read
//            bytes are taken from tx_data with a one-cycle tx_req pulse.
//            SDA is open-drain. SCL is never driven and the clock is never
//            stretched.
// Ports    : clk      - system clock, at least 16x the SCL frequency
//            reset    - asynchronous, active-high reset
//            scl      - bus clock from the master
//            sda      - bus data, open-drain (0 or z)
//            tx_data  - byte for the next read slot
//            tx_req   - pulse when tx_data is captured
//            rx_data  - last byte written by the master
//            rx_valid - pulse when rx_data updates
//            busy     - high whenever the FSM is not idle
// Revision : 1.0 - initial release
// ============================================================================
module i2c_slave #(
  parameter logic [6:0] DEV_ADDR    = 7'h42,
  parameter int         SYNC_STAGES = 2      // minimum 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  tri         sda,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_ADDR_ACK = 3'd2;
  localparam logic [2:0] S_WR_DATA  = 3'd3;
  localparam logic [2:0] S_WR_ACK   = 3'd4;
  localparam logic [2:0] S_RD_DATA  = 3'd5;
  localparam logic [2:0] S_RD_ACK   = 3'd6;

  // --------------------------------------------------------------------------
  // Input synchronisers and one-cycle history. Everything resets to 1 so an
  // idle (pulled-up) bus produces no spurious edges or START/STOP after reset.
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_p;
  logic                   r_sda_p;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_p    <= 1'b1;
      r_sda_p    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda};
      r_scl_p    <= r_scl_sync[SYNC_STAGES-1];
      r_sda_p    <= r_sda_sync[SYNC_STAGES-1];
    end
  end

  logic w_scl_s;
  logic w_sda_s;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;

  assign w_scl_s    = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_s    = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = !r_scl_p &  w_scl_s;
  assign w_scl_fall =  r_scl_p & !w_scl_s;
  // Any SDA edge while SCL is high is a bus condition, never data.
  assign w_start    = w_scl_s &  r_sda_p & !w_sda_s;
  assign w_stop     = w_scl_s & !r_sda_p &  w_sda_s;

  // --------------------------------------------------------------------------
  // Protocol FSM
  // --------------------------------------------------------------------------
  logic [2:0] r_state;
  logic [3:0] r_bit_cnt;
  logic [7:0] r_shreg;
  logic       r_rw;
  logic       r_ack_ok;   // master ACKed the last read byte
  logic       r_sda_low;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_tx_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= 4'd0;
      r_shreg    <= 8'd0;
      r_rw       <= 1'b0;
      r_ack_ok   <= 1'b0;
      r_sda_low  <= 1'b0;
      r_rx_data  <= 8'd0;
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;

      if (w_stop) begin
        r_state   <= S_IDLE;
        r_sda_low <= 1'b0;
      end else if (w_start) begin
        r_state   <= S_ADDR;
        r_bit_cnt <= 4'd0;
        r_sda_low <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_sda_low <= 1'b0;
          end

          S_ADDR: begin
            if (w_scl_rise) begin
              r_shreg   <= {r_shreg[6:0], w_sda_s};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
              if (r_shreg[7:1] == DEV_ADDR) begin
                r_rw      <= r_shreg[0];
                r_sda_low <= 1'b1;
                r_state   <= S_ADDR_ACK;
              end else begin
                // Not for us: stay deaf until the next START.
                r_state <= S_IDLE;
              end
            end
          end

          S_ADDR_ACK: begin
            // The fall that ends the ACK clock starts the data phase.
            if (w_scl_fall) begin
              r_bit_cnt <= 4'd0;
              if (!r_rw) begin
                r_sda_low <= 1'b0;
                r_state   <= S_WR_DATA;
              end else begin
                r_shreg   <= tx_data;
                r_tx_req  <= 1'b1;
                r_sda_low <= !tx_data[7];
                r_state   <= S_RD_DATA;
              end
            end
          end

          S_WR_DATA: begin
            if (w_scl_rise) begin
              r_shreg   <= {r_shreg[6:0], w_sda_s};
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd7) begin
                r_rx_data  <= {r_shreg[6:0], w_sda_s};
                r_rx_valid <= 1'b1;
              end
            end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
              r_sda_low <= 1'b1;
              r_state   <= S_WR_ACK;
            end
          end

          S_WR_ACK: begin
            if (w_scl_fall) begin
              r_sda_low <= 1'b0;
              r_bit_cnt <= 4'd0;
              r_state   <= S_WR_DATA;
            end
          end

          S_RD_DATA: begin
            // Bit 7 went out on entry; each fall advances to the next bit,
            // and the fall after bit 0 hands SDA to the master for ACK.
            if (w_scl_fall) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd7) begin
                r_sda_low <= 1'b0;
                r_ack_ok  <= 1'b0;
                r_state   <= S_RD_ACK;
              end else begin
                r_shreg   <= {r_shreg[6:0], 1'b0};
                r_sda_low <= !r_shreg[6];
              end
            end
          end

          S_RD_ACK: begin
            if (w_scl_rise) begin
              if (w_sda_s) begin
                r_state <= S_IDLE;
              end else begin
                r_ack_ok <= 1'b1;
              end
            end else if (w_scl_fall && r_ack_ok) begin
              r_shreg   <= tx_data;
              r_tx_req  <= 1'b1;
              r_sda_low <= !tx_data[7];
              r_bit_cnt <= 4'd0;
              r_state   <= S_RD_DATA;
            end
          end

          default: begin
            r_state   <= S_IDLE;
            r_sda_low <= 1'b0;
          end
        endcase
      end
    end
  end

  // Open-drain pad: only ever pulls low.
  assign sda      = r_sda_low ? 1'b0 : 1'bz;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign tx_req   = r_tx_req;
  assign busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_i2c_slave
// Purpose  : Self-checking bench for i2c_slave. A bus-level master model
//            drives SCL/SDA; expected write bytes are queued when issued and
//            popped by a monitor on rx_valid; read bytes are checked against
//            the sequence of bytes presented on tx_data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_slave;

  localparam int Q = 80;   // quarter SCL period in ns (8 clk)

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       scl   = 1'b1;
  logic       m_low = 1'b0;
  logic [7:0] tx_data;
  logic       tx_req;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  wire        sda;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_slave #(.DEV_ADDR(7'h42), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .scl      (scl),
    .sda      (sda),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_rx_q[$];
  logic [7:0] tx_seq[0:255];
  int         tx_ptr = 0;   // advanced by every tx_req seen
  int         rd_idx = 0;   // read bytes the master has consumed

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic prev_rxv = 1'b0;
  always @(negedge clk) begin
    if (rx_valid) begin
      chk("rx_valid_one_cycle", int'(prev_rxv), 0);
      chk("rxv_txreq_exclusive", int'(tx_req), 0);
      if (exp_rx_q.size() == 0)
        chk("rx_unexpected", 1, 0);
      else
        chk("rx_data", int'(rx_data), int'(exp_rx_q.pop_front()));
    end
    prev_rxv = rx_valid;
  end

  // ---------------- user-side tx responder ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (tx_req) begin
        tx_ptr++;
        tx_data = tx_seq[tx_ptr];
      end
    end
  end

  // ---------------- bus master primitives ----------------
  task automatic bus_start();
    m_low = 1'b0; #Q;
    scl   = 1'b1; #Q;
    m_low = 1'b1; #Q;
    scl   = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    m_low = 1'b1; #Q;
    scl   = 1'b1; #Q;
    m_low = 1'b0; #Q;
  endtask

  task automatic wbit(input logic b);
    m_low = !b; #Q;
    scl   = 1'b1; #(2*Q);
    scl   = 1'b0; #Q;
  endtask

  task automatic rbit(output logic b);
    m_low = 1'b0; #Q;
    scl   = 1'b1; #Q;
    b     = (sda === 1'b0) ? 1'b0 : 1'b1;
    #Q;
    scl   = 1'b0; #Q;
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack_bit);
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(ack_bit);
  endtask

  task automatic rbyte(input logic master_ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
    wbit(master_ack ? 1'b0 : 1'b1);
  endtask

  // ---------------- transaction-level model ----------------
  logic [7:0] wdat[0:15];

  task automatic write_txn(input logic [6:0] a, input int n);
    logic ack_bit;
    bit   match;
    match = (a == 7'h42);
    @(negedge clk);
    bus_start();
    wbyte({a, 1'b0}, ack_bit);
    chk("addr_ack", int'(ack_bit), match ? 0 : 1);
    if (!match) chk("busy_after_mismatch", int'(busy), 0);
    for (int k = 0; k < n; k++) begin
      if (match) exp_rx_q.push_back(wdat[k]);
      wbyte(wdat[k], ack_bit);
      chk("data_ack", int'(ack_bit), match ? 0 : 1);
    end
    bus_stop();
    repeat (4) @(negedge clk);
    chk("busy_after_stop", int'(busy), 0);
    chk("rx_queue_drained", exp_rx_q.size(), 0);
    if (match && n > 0) chk("rx_data_held", int'(rx_data), int'(wdat[n-1]));
  endtask

  task automatic read_txn(input int n);
    logic       ack_bit;
    logic [7:0] d;
    logic [7:0] e;
    @(negedge clk);
    bus_start();
    wbyte({7'h42, 1'b1}, ack_bit);
    chk("rd_addr_ack", int'(ack_bit), 0);
    for (int k = 0; k < n; k++) begin
      e = tx_seq[rd_idx];
      rd_idx++;
      rbyte(k != n - 1, d);
      chk("rd_data", int'(d), int'(e));
    end
    chk("busy_after_nack", int'(busy), 0);
    chk("sda_released_after_nack", int'(sda === 1'b1), 1);
    bus_stop();
    repeat (4) @(negedge clk);
    chk("tx_req_count", tx_ptr, rd_idx);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic       ack_bit;
    logic [7:0] d;
    int         n;
    int         tx_base;

    for (int i = 0; i < 256; i++) tx_seq[i] = 8'($urandom);
    tx_seq[0] = 8'hA5;
    tx_seq[1] = 8'h3C;
    tx_data   = tx_seq[0];

    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_rx_data", int'(rx_data), 0);
    chk("reset_rx_valid", int'(rx_valid), 0);
    chk("reset_tx_req", int'(tx_req), 0);
    chk("reset_sda", int'(sda === 1'b1), 1);

    // Write to own address
    wdat[0] = 8'h5A; wdat[1] = 8'hC3;
    write_txn(7'h42, 2);

    // Address mismatch (0x90 -> addr 0x48, W)
    wdat[0] = 8'h11;
    write_txn(7'h48, 1);

    // Read: 0xA5 ACKed, then 0x3C NACKed
    tx_base = tx_ptr;
    read_txn(2);
    chk("tx_req_pulses", tx_ptr - tx_base, 2);

    // Repeated START: write 0x07, then read one byte
    @(negedge clk);
    bus_start();
    wbyte(8'h84, ack_bit);
    chk("rs_addr_ack", int'(ack_bit), 0);
    exp_rx_q.push_back(8'h07);
    wbyte(8'h07, ack_bit);
    chk("rs_data_ack", int'(ack_bit), 0);
    bus_start();
    chk("rs_busy_in_addr", int'(busy), 1);
    wbyte(8'h85, ack_bit);
    chk("rs_rd_addr_ack", int'(ack_bit), 0);
    rbyte(1'b0, d);
    chk("rs_rd_data", int'(d), int'(tx_seq[rd_idx]));
    rd_idx++;
    bus_stop();
    repeat (4) @(negedge clk);
    chk("rs_rx_data", int'(rx_data), 8'h07);
    chk("rs_busy", int'(busy), 0);

    // STOP mid-byte
    @(negedge clk);
    bus_start();
    wbyte(8'h84, ack_bit);
    chk("mid_addr_ack", int'(ack_bit), 0);
    wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b1);
    bus_stop();
    repeat (4) @(negedge clk);
    chk("mid_busy", int'(busy), 0);
    chk("mid_sda", int'(sda === 1'b1), 1);
    wdat[0] = 8'hFF;
    write_txn(7'h42, 1);

    // Randomised mix of writes (own or foreign address) and reads
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        n = int'($urandom_range(1, 4));
        for (int k = 0; k < n; k++) wdat[k] = 8'($urandom);
        write_txn(($urandom_range(0, 1) == 0) ? 7'h42 : 7'($urandom_range(0, 65)), n);
      end else begin
        read_txn(int'($urandom_range(1, 3)));
      end
    end

    // Reset while driving SDA low in RD_DATA
    tx_seq[tx_ptr] = 8'h3C;
    tx_data        = 8'h3C;
    @(negedge clk);
    bus_start();
    wbyte(8'h85, ack_bit);
    chk("rst_rd_addr_ack", int'(ack_bit), 0);
    chk("rst_sda_driven", int'(sda === 1'b0), 1);
    rd_idx++;   // this byte is abandoned
    #3;
    reset = 1'b1;
    #1;
    chk("rst_sda_released", int'(sda === 1'b1), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rx_data", int'(rx_data), 0);
    chk("rst_rx_valid", int'(rx_valid), 0);
    chk("rst_tx_req", int'(tx_req), 0);
    scl   = 1'b1;
    m_low = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    wdat[0] = 8'h96; wdat[1] = 8'h01; wdat[2] = 8'hE7;
    write_txn(7'h42, 3);

    repeat (10) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C responder (target) for the 7-bit-address, byte-oriented protocol our I2C master drives.
- Oversamples SCL/SDA on the system clock. Detects START, repeated START and STOP, and matches the 7-bit device address.
- Write bytes from the bus are delivered to user logic with a one-cycle valid pulse. Read bytes are taken from user logic with a one-cycle request pulse.
- SDA is open-drain. The block never drives SCL and does no clock stretching.

Parameters:
- DEV_ADDR, 7'h42, 7-bit bus address this responder answers to.
- SYNC_STAGES, 2, flip-flop depth of the SCL/SDA input synchronisers (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 16x SCL frequency.
- reset  input  1  asynchronous, active-high reset.
- scl  input  1  bus clock, driven by the master (pulled up).
- sda  inout(tri)  1  bus data, open-drain: 1'b0 when driving low, otherwise 1'bz.
- tx_data  input  8  byte returned on the next read byte slot; must be valid whenever a read byte may start.
- tx_req  output  1  one-cycle pulse when tx_data is captured; user may update tx_data after this pulse.
- rx_data  output  8  last byte written by the master; held until the next write byte.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (asynchronous):
  - state=IDLE, SDA released (z), rx_data=0, rx_valid=0, tx_req=0, busy=0.
  - Synchroniser flops and history registers are set to 1.
  - Reset mid-transfer releases SDA immediately and abandons the transfer.
- Sampling:
  - scl_s and sda_s are the synchronised inputs; scl_p and sda_p are their values one clk earlier.
  - scl_rise = !scl_p & scl_s. scl_fall = scl_p & !scl_s.
  - START = scl_s & sda_p & !sda_s. STOP = scl_s & !sda_p & sda_s.
- Global priority: STOP, then START, then edge events.
  - STOP in any state: go to IDLE, release SDA.
  - START in any state (including a repeated START): go to ADDR, bit_cnt=0, release SDA.
- Internal sda_low register drives the pin: sda = sda_low ? 1'b0 : 1'bz.
- States and transitions:
  - IDLE: SDA released; wait for START.
  - ADDR:
    - On each scl_rise, shift sda_s into shreg (MSB first) and increment bit_cnt.
    - On the scl_fall after the 8th rise: if shreg[7:1]==DEV_ADDR, latch rw=shreg[0], set sda_low=1 and go to ADDR_ACK. Otherwise go to IDLE and ignore the bus until the next START.
  - ADDR_ACK: hold SDA low through the ACK high phase. On the next scl_fall:
    - rw=0: release SDA, bit_cnt=0, go to WR_DATA.
    - rw=1: load shreg=tx_data, pulse tx_req, drive sda_low=!tx_data[7], bit_cnt=0, go to RD_DATA.
  - WR_DATA:
    - Shift on each scl_rise.
    - After the 8th rise: rx_data=shreg (new byte included) and rx_valid=1 on the following clk.
    - On the next scl_fall: sda_low=1, go to WR_ACK. Every byte is ACKed; there is no NACK on write.
  - WR_ACK: on scl_fall, release SDA, bit_cnt=0, go to WR_DATA.
  - RD_DATA:
    - On each scl_fall: bit_cnt++.
    - If bit_cnt was 7 on that fall: release SDA and go to RD_ACK.
    - Otherwise: shift shreg left and drive sda_low=!shreg[6].
  - RD_ACK:
    - On scl_rise, sample the master's ACK.
    - ACK (sda_s==0): on the following scl_fall, reload shreg=tx_data, pulse tx_req, drive bit 7, go to RD_DATA.
    - NACK (sda_s==1): go to IDLE with SDA released; the master then issues STOP or repeated START.
- SDA changes only in the clk cycle a scl_fall is detected. This gives the master at least SYNC_STAGES+1 clk of hold after SCL goes low.
- rx_valid and tx_req are never high in the same cycle; each is high for exactly one clk per byte.
- bit_cnt is 4 bits; it clears on START and at every byte boundary.
- An SDA transition while SCL is high is always treated as START/STOP, never as data.

Test Plan:
- Write to own address: master sends START, 0x84 (addr 0x42, W), 0x5A, 0xC3, STOP -> ACK low on all 3 ACK slots; rx_valid pulses twice with rx_data 0x5A then 0xC3; busy falls after STOP.
- Address mismatch: START, 0x90, 0x11, STOP -> SDA never driven low (ACK slot reads 1); no rx_valid; busy returns to 0 after the mismatch.
- Read with ACK then NACK: tx_data=0xA5, updated to 0x3C after the first tx_req; START, 0x85, two read bytes, master ACKs then NACKs, STOP -> master receives 0xA5 then 0x3C; exactly two tx_req pulses; SDA released after the NACK.
- Repeated START: START, 0x84, 0x07, repeated START, 0x85, read 1 byte with NACK, STOP -> rx_data=0x07; read byte equals tx_data; state goes back to ADDR on the repeated START.
- STOP mid-byte: START, 0x84, 4 data bits, STOP -> IDLE, no rx_valid, SDA released; the next transaction with 0xFF succeeds.
- Reset mid-read: assert reset while SDA is driven low in RD_DATA -> SDA is z in the same cycle; all outputs 0; the following full write transaction completes correctly.
